cordic_vectoring: RTL

- Iterative CORDIC engine running in vectoring mode. It is the inverse of the sine/cosine rotation generator: it takes a Cartesian vector (X, Y) and returns its magnitude and its angle (atan2).
- It is used to recover phase and amplitude from the generator's sine/cosine outputs, and as a standalone atan2 unit.
- Multi-cycle operation: one micro-rotation per clock, controlled by a Start/Done handshake.

---
 rtl/cordic_vectoring.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC: (x, y) -> magnitude*K and atan2 angle
module cordic_vectoring #(
  parameter int ITER  = 14,
  parameter int GUARD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] mag_out,
  output logic signed [15:0] angle_out,
  output logic               mag_sat
);

  localparam int W = 16 + GUARD;

  localparam logic signed [W-1:0] MAG_MAX   = W'(32767);
  localparam logic signed [15:0]  HALF_PI   = 16'sd12868;
  localparam logic signed [16:0]  PI_POS    = 17'sd25736;
  localparam logic signed [16:0]  PI_NEG    = -17'sd25736;
  localparam logic [3:0]          LAST_STEP = 4'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITERATE,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]          iter_cnt;
  logic                zero_flag;
  logic signed [W-1:0] x_r, y_r;
  logic signed [15:0]  z_r;

  logic signed [W-1:0] x_ext, y_ext;
  logic signed [W-1:0] x_pre, y_pre;
  logic signed [15:0]  z_pre;
  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] x_nxt, y_nxt;
  logic signed [15:0]  atan_i;
  logic signed [16:0]  z_nxt;
  logic signed [15:0]  mag_nxt, angle_nxt;
  logic                sat_nxt;
  logic                last_step;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'sd6434;
      4'd1:    atan_lut = 16'sd3798;
      4'd2:    atan_lut = 16'sd2007;
      4'd3:    atan_lut = 16'sd1019;
      4'd4:    atan_lut = 16'sd511;
      4'd5:    atan_lut = 16'sd256;
      4'd6:    atan_lut = 16'sd128;
      4'd7:    atan_lut = 16'sd64;
      4'd8:    atan_lut = 16'sd32;
      4'd9:    atan_lut = 16'sd16;
      4'd10:   atan_lut = 16'sd8;
      4'd11:   atan_lut = 16'sd4;
      4'd12:   atan_lut = 16'sd2;
      4'd13:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  // Quadrant pre-rotation brings the vector into the right half-plane; the
  // negation is done after sign extension so -(-32768) is representable.
  always_comb begin
    x_ext = {{GUARD{x_in[15]}}, x_in};
    y_ext = {{GUARD{y_in[15]}}, y_in};
    if (!x_in[15]) begin
      x_pre = x_ext;
      y_pre = y_ext;
      z_pre = 16'sd0;
    end else if (!y_in[15]) begin
      x_pre = y_ext;
      y_pre = -x_ext;
      z_pre = HALF_PI;
    end else begin
      x_pre = -y_ext;
      y_pre = x_ext;
      z_pre = -HALF_PI;
    end
  end

  always_comb begin
    x_sh   = x_r >>> iter_cnt;
    y_sh   = y_r >>> iter_cnt;
    atan_i = atan_lut(iter_cnt);
    if (!y_r[W-1]) begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = {z_r[15], z_r} + {atan_i[15], atan_i};
    end else begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = {z_r[15], z_r} - {atan_i[15], atan_i};
    end
    last_step = (iter_cnt == LAST_STEP);
  end

  // Result formatting applied to the final micro-rotation's outputs.
  always_comb begin
    sat_nxt = 1'b0;
    if (x_nxt > MAG_MAX) begin
      mag_nxt = 16'sd32767;
      sat_nxt = 1'b1;
    end else if (x_nxt[W-1]) begin
      mag_nxt = 16'sd0;
    end else begin
      mag_nxt = x_nxt[15:0];
    end

    if (z_nxt > PI_POS) begin
      angle_nxt = PI_POS[15:0];
    end else if (z_nxt < PI_NEG) begin
      angle_nxt = PI_NEG[15:0];
    end else begin
      angle_nxt = z_nxt[15:0];
    end

    if (zero_flag) begin
      mag_nxt   = 16'sd0;
      angle_nxt = 16'sd0;
      sat_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ITERATE;
        end
      end
      S_ITERATE: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt  <= 4'd0;
      zero_flag <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      mag_out   <= '0;
      angle_out <= '0;
      mag_sat   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        x_r       <= x_pre;
        y_r       <= y_pre;
        z_r       <= z_pre;
        iter_cnt  <= 4'd0;
        zero_flag <= (x_in == 16'sd0) && (y_in == 16'sd0);
      end else if (state == S_ITERATE) begin
        x_r      <= x_nxt;
        y_r      <= y_nxt;
        z_r      <= z_nxt[15:0];
        iter_cnt <= iter_cnt + 4'd1;
        if (last_step) begin
          mag_out   <= mag_nxt;
          angle_out <= angle_nxt;
          mag_sat   <= sat_nxt;
        end
      end
    end
  end

endmodule
